fetch_sequencer: RTL and testbench

Instruction-cycle sequencer for the Nandy core. It fetches each instruction byte into the instruction register and steps the `cycle` phase that the instruction decoder consumes. Instructions with `inst[7]=1` run two phases (cycle 0 then cycle 1); all others run one. It also owns the program counter, applies jumps at instruction commit, and handles single-level interrupt entry with a saved return address.

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-cycle sequencer for the Nandy core.
//
// This block fetches one instruction byte into the instruction register. It then
// steps through the execute phases that the decoder consumes:
//   - inst[7]=1: two phases (cycle 0, then cycle 1);
//   - otherwise: one phase.
// It also owns the program counter, applies jumps when an instruction retires,
// and performs single-level interrupt entry with a saved return address.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   mem_rdata/ready instruction byte from memory and its valid flag
//   fetch_req       fetch request; the fetch address is pc
//   stall           holds the current execute phase
//   jump/long_jump  decoder jump controls, sampled only at commit
//   jump_target     new pc when a jump is taken at commit
//   cli/sti         clear/set the interrupt enable at commit (cli wins)
//   irq             level-sensitive interrupt request, checked at commit
//   inst, cycle     instruction register and current execute phase
//   exec_valid      high in both execute phases
//   commit          pulse in the cycle an instruction retires
//   pc, epc, ie     program counter, saved return pc, interrupt enable
module fetch_sequencer #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] IRQ_VECTOR = 16'h0004
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      mem_rdata,
  input  logic            mem_ready,
  output logic            fetch_req,
  input  logic            stall,
  input  logic            jump,
  input  logic            long_jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            cli,
  input  logic            sti,
  input  logic            irq,
  output logic [7:0]      inst,
  output logic            cycle,
  output logic            exec_valid,
  output logic            commit,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] epc,
  output logic            ie
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC0 = 2'b01,
    EXEC1 = 2'b10,
    IRQ   = 2'b11
  } state_t;

  state_t state;
  logic   ie_next;

  // Decode the phase outputs from the current state.
  // An instruction retires when its last phase is not stalled.
  always_comb begin
    fetch_req  = 1'b0;
    exec_valid = 1'b0;
    cycle      = 1'b0;
    commit     = 1'b0;
    case (state)
      FETCH: fetch_req = 1'b1;
      EXEC0: begin
        exec_valid = 1'b1;
        commit     = ~stall & ~inst[7];
      end
      EXEC1: begin
        exec_valid = 1'b1;
        cycle      = 1'b1;
        commit     = ~stall;
      end
      IRQ:     fetch_req = 1'b0;
      default: fetch_req = 1'b0;
    endcase
  end

  // Compute the interrupt enable that would result if the instruction retired now.
  // When both cli and sti are high, cli takes priority.
  always_comb begin
    if (cli) begin
      ie_next = 1'b0;
    end else if (sti) begin
      ie_next = 1'b1;
    end else begin
      ie_next = ie;
    end
  end

  // Sequencer state, program counter, instruction register and interrupt state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      inst  <= 8'h00;
      epc   <= '0;
      ie    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            inst  <= mem_rdata;
            pc    <= pc + PC_W'(1);
            state <= EXEC0;
          end
        end
        EXEC0: begin
          if (!stall && inst[7]) begin
            state <= EXEC1;
          end
        end
        EXEC1: begin
          // The retire step is applied by the commit branch below.
        end
        IRQ: begin
          // The pc here already includes any jump taken at the preceding commit.
          epc   <= pc;
          pc    <= IRQ_VECTOR;
          ie    <= 1'b0;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase

      if (commit) begin
        if (jump || long_jump) begin
          pc <= jump_target;
        end
        ie    <= ie_next;
        state <= (irq && ie_next) ? IRQ : FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer.
// The reference model tracks each instruction as a byte plus a phase count.
// Every cycle, the bench compares all DUT outputs against that model.
// It runs directed scenarios first, then randomized traffic.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        fetch_req;
  logic        stall;
  logic        jump;
  logic        long_jump;
  logic [15:0] jump_target;
  logic        cli;
  logic        sti;
  logic        irq;
  logic [7:0]  inst;
  logic        cycle;
  logic        exec_valid;
  logic        commit;
  logic [15:0] pc;
  logic [15:0] epc;
  logic        ie;

  int checks = 0;
  int errors = 0;

  // Reference model, kept at the instruction level.
  int   m_pc;
  int   m_epc;
  bit   m_ie;
  int   m_inst;
  bit   m_have_inst;  // an instruction byte is held and executing
  int   m_phase;      // index of the current execute phase
  bit   m_irq_entry;  // the next cycle is the interrupt-entry cycle

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W(16), .RESET_PC(16'h0000), .IRQ_VECTOR(16'h0004)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .fetch_req(fetch_req), .stall(stall), .jump(jump), .long_jump(long_jump),
    .jump_target(jump_target), .cli(cli), .sti(sti), .irq(irq), .inst(inst),
    .cycle(cycle), .exec_valid(exec_valid), .commit(commit), .pc(pc),
    .epc(epc), .ie(ie)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int num_phases(input int byte_val);
    return ((byte_val / 128) % 2 == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_pc        = 0;
    m_epc       = 0;
    m_ie        = 1'b0;
    m_inst      = 0;
    m_have_inst = 1'b0;
    m_phase     = 0;
    m_irq_entry = 1'b0;
  endtask

  task automatic set_idle();
    mem_ready   = 1'b0;
    mem_rdata   = 8'h00;
    stall       = 1'b0;
    jump        = 1'b0;
    long_jump   = 1'b0;
    jump_target = 16'h0000;
    cli         = 1'b0;
    sti         = 1'b0;
    irq         = 1'b0;
  endtask

  // One clock cycle:
  //   1. At the falling edge, compare all outputs against the model.
  //   2. Advance the model using the inputs currently applied.
  //   3. Pass the rising edge, then allow a small settling delay.
  task automatic tick();
    bit exp_commit;
    bit new_ie;
    @(negedge clk);
    exp_commit = m_have_inst && !stall && (m_phase == num_phases(m_inst) - 1);
    check("fetch_req",  32'(fetch_req),  32'(!m_have_inst && !m_irq_entry));
    check("exec_valid", 32'(exec_valid), 32'(m_have_inst));
    check("cycle",      32'(cycle),      32'(m_phase));
    check("commit",     32'(commit),     32'(exp_commit));
    check("pc",         32'(pc),         32'(m_pc));
    check("inst",       32'(inst),       32'(m_inst));
    check("epc",        32'(epc),        32'(m_epc));
    check("ie",         32'(ie),         32'(m_ie));
    if (!rst_n) begin
      model_reset();
    end else if (m_irq_entry) begin
      m_epc       = m_pc;
      m_pc        = 4;
      m_ie        = 1'b0;
      m_irq_entry = 1'b0;
    end else if (!m_have_inst) begin
      if (mem_ready) begin
        m_inst      = int'(mem_rdata);
        m_pc        = (m_pc + 1) % 65536;
        m_have_inst = 1'b1;
        m_phase     = 0;
      end
    end else if (!stall) begin
      if (m_phase < num_phases(m_inst) - 1) begin
        m_phase = m_phase + 1;
      end else begin
        if (jump || long_jump) m_pc = int'(jump_target);
        new_ie      = cli ? 1'b0 : (sti ? 1'b1 : m_ie);
        m_ie        = new_ie;
        m_have_inst = 1'b0;
        m_phase     = 0;
        m_irq_entry = irq && new_ie;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Fetch and retire one single-phase instruction with no stalls.
  task automatic one_phase_inst(input logic [7:0] b);
    mem_ready = 1'b1;
    mem_rdata = b;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check("reset_pc",        32'(pc),        32'h0);
    check("reset_inst",      32'(inst),      32'h0);
    check("reset_ie",        32'(ie),        32'h0);
    check("reset_fetch_req", 32'(fetch_req), 32'h1);

    // Single-phase sequence: 8'h10 then 8'h22.
    mem_ready = 1'b1;
    mem_rdata = 8'h10;
    tick();
    check("seq_pc_after_first",  32'(pc), 32'h1);
    tick();
    mem_rdata = 8'h22;
    tick();
    check("seq_pc_after_second", 32'(pc), 32'h2);
    tick();

    // Two-phase instruction 8'h85, stalled for two cycles in the second phase.
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = 8'h85;
    tick();
    mem_ready = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    tick();
    check("two_phase_pc", 32'(pc), 32'h1);

    // Jump taken when a two-phase instruction retires.
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = 8'hE0;
    tick();
    mem_ready = 1'b0;
    tick();
    jump        = 1'b1;
    jump_target = 16'h0100;
    tick();
    set_idle();
    check("jump_pc",        32'(pc),        32'h0100);
    check("jump_fetch_req", 32'(fetch_req), 32'h1);

    // Interrupt entry from the instruction at pc 5.
    do_reset();
    sti = 1'b1;
    for (int i = 0; i < 5; i++) one_phase_inst(8'h01);
    check("irq_pre_pc", 32'(pc), 32'h5);
    check("irq_pre_ie", 32'(ie), 32'h1);
    irq = 1'b1;
    one_phase_inst(8'h02);
    check("irq_entry_cycle", 32'(fetch_req | exec_valid), 32'h0);
    tick();
    check("irq_epc", 32'(epc), 32'h6);
    check("irq_pc",  32'(pc),  32'h0004);
    check("irq_ie",  32'(ie),  32'h0);

    // Same situation, but cli at commit blocks the interrupt.
    irq = 1'b0;
    one_phase_inst(8'h03);
    irq = 1'b1;
    cli = 1'b1;
    one_phase_inst(8'h04);
    check("cli_no_irq", 32'(fetch_req), 32'h1);
    check("cli_ie",     32'(ie),        32'h0);
    set_idle();

    // Fetch wait at pc 16'hFFFF, followed by wrap-around.
    do_reset();
    jump        = 1'b1;
    jump_target = 16'hFFFF;
    one_phase_inst(8'h05);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_pc",        32'(pc),        32'hFFFF);
      check("wait_fetch_req", 32'(fetch_req), 32'h1);
    end
    mem_ready = 1'b1;
    mem_rdata = 8'h06;
    tick();
    check("wrap_pc", 32'(pc), 32'h0);
    mem_ready = 1'b0;
    tick();

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(63) != 0);
      mem_ready   = ($urandom_range(3) != 0);
      mem_rdata   = 8'($urandom);
      stall       = ($urandom_range(3) == 0);
      jump        = ($urandom_range(7) == 0);
      long_jump   = ($urandom_range(7) == 0);
      jump_target = 16'($urandom);
      cli         = ($urandom_range(5) == 0);
      sti         = ($urandom_range(2) == 0);
      irq         = ($urandom_range(2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
